// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single backing-memory port between the icache refill engine and
// the dcache refill/writeback engine. One line transaction is in flight at a
// time; a granted transaction is never preempted. When both caches request in
// the same IDLE cycle, the one that did not win last time is granted.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   ic_req/ic_addr        icache line-read request (held until ic_ready)
//   ic_ready/ic_rdata     one-cycle completion pulse and returned line
//   dc_req/dc_we/dc_addr  dcache request (dc_we = 1 for writeback)
//   dc_wdata              dcache writeback line
//   dc_ready/dc_rdata     one-cycle completion pulse and returned line (reads)
//   mem_req/mem_we        memory request (held until mem_ack) and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata/mem_ack     memory read data and one-cycle completion pulse
//   busy                  high whenever the arbiter is not idle

module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StBusyIc,
        StBusyDc,
        StRespIc,
        StRespDc
    } state_e;

    localparam logic GntIc = 1'b0;
    localparam logic GntDc = 1'b1;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;

    // dcache wins if it is the only requester, or if both request and the
    // icache was the previous winner.
    logic grant_dc;
    assign grant_dc = dc_req && (!ic_req || (last_grant_q == GntIc));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;

        unique case (state_q)
            StIdle: begin
                // mem_ack is ignored here: a stray ack cannot complete anything.
                if (ic_req || dc_req) begin
                    mem_req_d = 1'b1;
                    if (grant_dc) begin
                        state_d      = StBusyDc;
                        last_grant_d = GntDc;
                        mem_we_d     = dc_we;
                        mem_addr_d   = dc_addr;
                        mem_wdata_d  = dc_wdata;
                    end else begin
                        state_d      = StBusyIc;
                        last_grant_d = GntIc;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = ic_addr;
                        mem_wdata_d  = '0;
                    end
                end
            end

            // Requester inputs are not looked at while busy; the memory
            // outputs keep the values captured at the grant edge.
            StBusyIc: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    ic_rdata_d = mem_rdata;
                    state_d    = StRespIc;
                end
            end

            StBusyDc: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    // A writeback returns no data, so dc_rdata keeps its value.
                    if (!mem_we_q) begin
                        dc_rdata_d = mem_rdata;
                    end
                    state_d = StRespDc;
                end
            end

            StRespIc: state_d = StIdle;
            StRespDc: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GntIc;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ic_rdata_q   <= '0;
            dc_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
        end
    end

    assign ic_ready  = (state_q == StRespIc);
    assign dc_ready  = (state_q == StRespDc);
    assign busy      = (state_q != StIdle);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester tasks push expected
// transactions into per-cache queues, a memory model answers mem_req, and a
// negedge monitor predicts the port behaviour from the arbitration rules.

module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;

    localparam int PIdle = 0;
    localparam int PBusy = 1;
    localparam int PResp = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic [LW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic [LW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ready  (dc_ready),
        .dc_rdata  (dc_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t          ic_q[$];
    txn_t          dc_q[$];
    bit            ready_log[$];   // 0 = icache, 1 = dcache, in completion order
    int            n_checks = 0;
    int            n_pass = 0;
    int            mem_req_cnt = 0;
    logic [LW-1:0] mem_store [logic [AW-1:0]];
    logic [LW-1:0] dc_shadow [logic [AW-1:0]];
    logic [LW-1:0] dc_last_exp = '0;
    bit            mem_auto = 1'b0;
    int            mem_fixed_delay = -1;

    // Reference model state
    int            m_phase = PIdle;
    bit            m_owner = 1'b0;
    bit            m_last = 1'b0;
    txn_t          m_txn;
    logic [LW-1:0] ic_hold = '0;
    logic [LW-1:0] dc_hold = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] pattern(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1357_9BDF, {a[15:0], a[31:16]}};
    endfunction

    function automatic logic [LW-1:0] mem_lookup(input logic [AW-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return pattern(a);
    endfunction

    function automatic logic [15:0] log_pack();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < ready_log.size() && i < 8; i++) b[i] = ready_log[i];
        return {8'(ready_log.size()), b};
    endfunction

    task automatic ic_txn(input logic [AW-1:0] a, input logic [LW-1:0] e);
        txn_t t;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        ic_req  = 1'b1;
        ic_addr = a;
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.rdata = e;
        ic_q.push_back(t);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ic_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ic_timeout: no ic_ready within 100 cycles, addr %h", a);
        end
        @(posedge clk); #1;
        ic_req = 1'b0;
    endtask

    task automatic dc_txn(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        txn_t t;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        dc_req   = 1'b1;
        dc_we    = we;
        dc_addr  = a;
        dc_wdata = wd;
        t.we = we; t.addr = a; t.wdata = wd;
        if (we) begin
            t.rdata = dc_last_exp;
            dc_shadow[a] = wd;
        end else begin
            t.rdata = dc_shadow.exists(a) ? dc_shadow[a] : pattern(a);
            dc_last_exp = t.rdata;
        end
        dc_q.push_back(t);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dc_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL dc_timeout: no dc_ready within 100 cycles, addr %h", a);
        end
        @(posedge clk); #1;
        dc_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset   = 1'b1;
        ic_req  = 1'b0;
        dc_req  = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        reset       = 1'b0;
        dc_last_exp = '0;
    endtask

    // Memory model: acks 'delay' cycles after first seeing mem_req.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mem_auto && mem_req && !reset) begin
                int d;
                d = (mem_fixed_delay >= 0) ? mem_fixed_delay : int'($urandom_range(0, 3));
                repeat (d) begin @(posedge clk); #1; end
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                mem_rdata = mem_we ? {$urandom, $urandom, $urandom, $urandom}
                                   : mem_lookup(mem_addr);
                mem_ack = 1'b1;
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor / reference model: idle -> busy on any request (round-robin on
    // conflict), busy -> resp on mem_ack, resp -> idle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_phase = PIdle;
                m_last  = 1'b0;
                ic_hold = '0;
                dc_hold = '0;
                ic_q.delete();
                dc_q.delete();
            end else begin
                if (mem_req === 1'b1) mem_req_cnt++;
                if (ic_ready === 1'b1) ready_log.push_back(1'b0);
                if (dc_ready === 1'b1) ready_log.push_back(1'b1);
                chk("ctrl{mem_req,ic_ready,dc_ready,busy}",
                    {mem_req, ic_ready, dc_ready, busy},
                    {m_phase == PBusy, m_phase == PResp && !m_owner,
                     m_phase == PResp && m_owner, m_phase != PIdle});
                case (m_phase)
                    PIdle: begin
                        chk("rdata_hold", {ic_rdata, dc_rdata}, {ic_hold, dc_hold});
                        if (ic_req || dc_req) begin
                            m_owner = (ic_req && dc_req) ? !m_last : dc_req;
                            m_last  = m_owner;
                            if ((m_owner && dc_q.size() == 0) || (!m_owner && ic_q.size() == 0)) begin
                                n_checks++;
                                $display("FAIL grant_queue: no expected txn for owner %0d", m_owner);
                            end else begin
                                m_txn = m_owner ? dc_q[0] : ic_q[0];
                            end
                            m_phase = PBusy;
                        end
                    end
                    PBusy: begin
                        chk("mem_bus{we,addr,wdata}", {mem_we, mem_addr, mem_wdata},
                            {m_txn.we, m_txn.addr, m_txn.wdata});
                        chk("rdata_hold", {ic_rdata, dc_rdata}, {ic_hold, dc_hold});
                        if (mem_ack) m_phase = PResp;
                    end
                    default: begin
                        if (m_owner) begin
                            chk("dc_rdata", dc_rdata, m_txn.rdata);
                            chk("ic_rdata_hold", ic_rdata, ic_hold);
                            dc_hold = m_txn.rdata;
                            if (dc_q.size() > 0) void'(dc_q.pop_front());
                        end else begin
                            chk("ic_rdata", ic_rdata, m_txn.rdata);
                            chk("dc_rdata_hold", dc_rdata, dc_hold);
                            ic_hold = m_txn.rdata;
                            if (ic_q.size() > 0) void'(ic_q.pop_front());
                        end
                        m_phase = PIdle;
                    end
                endcase
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, busy}, '0);
        chk("reset_rdata", {ic_rdata, dc_rdata}, '0);

        // Single icache read, memory acks in the third mem_req cycle
        mem_store[32'h40] = 128'hDEADBEEF_0000_0001_2222_3333;
        mem_auto = 1'b1;
        mem_fixed_delay = 2;
        ready_log.delete();
        mem_req_cnt = 0;
        ic_txn(32'h40, 128'hDEADBEEF_0000_0001_2222_3333);
        chk("t1_mem_req_cycles", mem_req_cnt, 3);
        chk("t1_ready_log", log_pack(), {8'd1, 8'h00});

        // Dcache writeback
        ready_log.delete();
        mem_fixed_delay = 1;
        dc_txn(1'b1, 32'h100, {16{8'hA5}});
        chk("t2_ready_log", log_pack(), {8'd1, 8'h01});
        chk("t2_dc_rdata", dc_rdata, '0);

        // Simultaneous pairs after reset: dcache, icache, dcache, icache
        do_reset();
        ready_log.delete();
        mem_fixed_delay = -1;
        for (int k = 0; k < 2; k++) begin
            fork
                ic_txn(32'h1100 + 32'(k * 16), pattern(32'h1100 + 32'(k * 16)));
                dc_txn(1'b0, 32'h8000 + 32'(k * 16), '0);
            join
        end
        chk("t3_grant_order", log_pack(), {8'd4, 8'h05});

        // icache request arrives one cycle into a dcache transaction
        ready_log.delete();
        mem_fixed_delay = 3;
        fork
            dc_txn(1'b0, 32'h8030, '0);
            begin
                @(posedge clk);
                ic_txn(32'h1300, pattern(32'h1300));
            end
        join
        chk("t4_grant_order", log_pack(), {8'd2, 8'h01});

        // Reset in the middle of an icache transaction, late ack afterwards
        mem_auto = 1'b0;
        ready_log.delete();
        @(posedge clk); #1;
        ic_req  = 1'b1;
        ic_addr = 32'h1230;
        ic_q.push_back('{we: 1'b0, addr: 32'h1230, wdata: '0, rdata: pattern(32'h1230)});
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL t5_grant: mem_req not raised within 20 cycles");
        end
        do_reset();
        mem_ack   = 1'b1;
        mem_rdata = {4{32'hBAD0_0BAD}};
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_outputs_zero",
                {mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, busy}, '0);
            chk("t5_rdata_zero", {ic_rdata, dc_rdata}, '0);
        end
        chk("t5_no_ready", log_pack(), {8'd0, 8'h00});

        // Stray mem_ack in IDLE after a completed read
        mem_auto = 1'b1;
        mem_fixed_delay = -1;
        ic_txn(32'h1200, pattern(32'h1200));
        mem_auto  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = {4{32'h0F0F_F0F0}};
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rdata_kept", {ic_rdata, dc_rdata}, {pattern(32'h1200), 128'h0});
        chk("t6_ready_log", log_pack(), {8'd1, 8'h00});

        // Randomised concurrent traffic
        mem_auto = 1'b1;
        mem_fixed_delay = -1;
        fork
            for (int n = 0; n < 25; n++) begin
                logic [AW-1:0] a;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                a = 32'h1000 + (32'($urandom_range(0, 255)) << 4);
                ic_txn(a, pattern(a));
            end
            for (int n = 0; n < 25; n++) begin
                logic [AW-1:0] a;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                a = 32'h8000 + (32'($urandom_range(0, 15)) << 4);
                dc_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
            end
        join
        repeat (3) @(negedge clk);
        chk("final_queues_empty", ic_q.size() + dc_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single backing-memory port between the instruction-cache and data-cache miss/writeback engines.
- Sits below both caches. The pipeline stalls via the caches' own miss signals while a transaction is outstanding.
- Serves one line transaction at a time through a registered FSM. Uses round-robin tie-breaking and never preempts a granted transaction.

Parameters:
- ADDR_W, 32, byte-address width of requests and memory port.
- LINE_W, 128, cache-line data width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ic_req  in  1  icache line-read request, held until ic_ready sampled.
- ic_addr  in  ADDR_W  icache line address, stable while ic_req high.
- ic_ready  out  1  one-cycle pulse: ic_rdata valid.
- ic_rdata  out  LINE_W  line returned to icache.
- dc_req  in  1  dcache request, held until dc_ready sampled.
- dc_we  in  1  1 = writeback, 0 = line read.
- dc_addr  in  ADDR_W  dcache line address.
- dc_wdata  in  LINE_W  writeback line.
- dc_ready  out  1  one-cycle pulse: dcache transaction complete.
- dc_rdata  out  LINE_W  line returned to dcache (reads only).
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from memory.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state = IDLE, last_grant = IC. All outputs 0, including ic_rdata and dc_rdata.
- Reset mid-transaction: abandons the transaction and emits no ready pulse. A later stray mem_ack is ignored.
- States:
  - IDLE.
  - BUSY_IC.
  - BUSY_DC.
  - RESP_IC.
  - RESP_DC.
- IDLE transitions:
  - Only dc_req high -> BUSY_DC.
  - Only ic_req high -> BUSY_IC.
  - Both high -> grant the requester not equal to last_grant. Because last_grant resets to IC, the first conflict goes to dcache.
  - Neither -> stay in IDLE.
- At the grant edge:
  - mem_addr / mem_we / mem_wdata are loaded from the winner. For an icache grant, mem_we = 0 and mem_wdata = 0.
  - mem_req is set to 1.
  - last_grant is updated to the winner.
- BUSY_x:
  - mem_req and the memory outputs are held constant until mem_ack is sampled high.
  - On mem_ack: mem_req <= 0, go to RESP_x.
  - For reads, the matching x_rdata <= mem_rdata. On a dcache write, dc_rdata keeps its previous value.
- Requester inputs are ignored while in BUSY; no re-sampling occurs.
- RESP_x: x_ready = 1 for exactly this cycle, then go to IDLE.
- Requester rule: a requester clears its req on the edge where it samples ready = 1, so req is already low in the following IDLE cycle. The arbiter does not filter a req that is still high; it is treated as a new request.
- Minimum latency, request seen in IDLE at cycle 0:
  - mem_req high in cycles 1..N, with mem_ack in cycle N.
  - ready in cycle N+1.
  - Next grant possible at the edge ending cycle N+2 (IDLE).
- mem_ack while in IDLE or RESP: ignored, no state change.
- Simultaneous request arrival during BUSY: the waiting requester is served next, regardless of priority, since only one other requester exists.
- Back-to-back conflicting traffic alternates IC/DC strictly, so neither requester starves.
- busy = (state != IDLE), registered from state.

Test Plan:
- Single icache read: ic_req=1, ic_addr=0x0000_0040; memory model acks 3 cycles after mem_req rises with mem_rdata=0xDEADBEEF_0000_0001_2222_3333 -> mem_req high 3 cycles with mem_addr=0x40 and mem_we=0; ic_ready pulses 1 cycle later with that data; dc_ready stays 0.
- Dcache writeback: dc_req=1, dc_we=1, dc_addr=0x100, dc_wdata=0xA5 repeated -> mem_we=1 and mem_wdata=0xA5 repeated; dc_ready pulses once; dc_rdata unchanged from reset value 0.
- Simultaneous requests after reset: ic_req and dc_req both rise in the same cycle -> dcache served first, then icache; a second simultaneous pair -> dcache then icache again, strictly alternating.
- Request arrives while busy: ic_req rises 1 cycle into a dcache transaction -> mem outputs remain dcache's until ack; icache is granted in the IDLE cycle after dc_ready.
- Reset asserted mid-transaction in BUSY_IC, with mem_ack arriving after reset deasserts -> all outputs 0, no ic_ready pulse, state stays IDLE, busy=0.
- Stray mem_ack in IDLE -> no ready pulse and no rdata change.
